// File: rtl/nn_parameters_pkg.sv
// Shared constants, state encoding and saturation helper for the dense-layer sequencers.
package nn_parameters;

  localparam int IN_SIZE_4  = 64;
  localparam int OUT_SIZE_4 = 10;
  localparam int ACC_W_4    = 24;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, EMIT, DONE} out_seq_state_t;

  // Clamp a sign-extended accumulator into the signed 16-bit logit range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] a);
    if (a > 32'sd32767)       return 16'sh7fff;
    else if (a < -32'sd32768) return 16'sh8000;
    else                      return a[15:0];
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over a stream of signed values; first value after clear always wins,
// afterwards only a strictly greater value replaces the best (ties keep the lower index).
module argmax_tracker #(
  parameter int IDX_W = 4,
  parameter int VAL_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    valid,
  input  logic        [IDX_W-1:0] idx,
  input  logic signed [VAL_W-1:0] value,
  output logic        [IDX_W-1:0] best_idx,
  output logic signed [VAL_W-1:0] best_val
);

  logic seen;

  // Best-so-far register with clear and strict-greater update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen     <= 1'b0;
      best_idx <= '0;
      best_val <= '0;
    end else if (clear) begin
      seen     <= 1'b0;
      best_idx <= '0;
      best_val <= '0;
    end else if (valid && (!seen || value > best_val)) begin
      seen     <= 1'b1;
      best_idx <= idx;
      best_val <= value;
    end
  end

endmodule

// File: rtl/output_layer_sequencer.sv
// Final dense layer controller: per neuron, bias + IN_SIZE sequential MACs against
// external 1-cycle-latency ROMs, saturate to 16 bits, stream the logit, track argmax.
module output_layer_sequencer
  import nn_parameters::*;
#(
  parameter int IN_SIZE  = IN_SIZE_4,
  parameter int OUT_SIZE = OUT_SIZE_4,
  parameter int ACC_W    = ACC_W_4,
  parameter int W_AW     = $clog2(IN_SIZE*OUT_SIZE),
  parameter int B_AW     = $clog2(OUT_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [IN_SIZE*8-1:0]   x_vec,
  output logic [W_AW-1:0]        w_addr,
  input  logic [7:0]             w_data,
  output logic [B_AW-1:0]        b_addr,
  input  logic [7:0]             b_data,
  output logic                   logit_valid,
  input  logic                   logit_ready,
  output logic [B_AW-1:0]        logit_idx,
  output logic [15:0]            logit_data,
  output logic                   busy,
  output logic                   class_valid,
  output logic [B_AW-1:0]        class_idx
);

  localparam int JW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  out_seq_state_t state_q, state_d;

  logic [IN_SIZE-1:0][7:0] x_q;
  logic [B_AW-1:0]         n_q;
  logic [JW-1:0]           j_q;
  logic [JW-1:0]           x_sel;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [31:0]      acc_sum32;
  logic [B_AW-1:0]         class_idx_q;
  logic [B_AW-1:0]         best_idx;
  logic signed [15:0]      best_val;
  logic                    unused_best;
  logic                    last_n;
  logic                    last_j;
  logic                    accept;

  assign last_n = (n_q == B_AW'(OUT_SIZE-1));
  assign last_j = (j_q == JW'(IN_SIZE-1));
  assign accept = (state_q == EMIT) && logit_ready;

  // j wraps to 0 when leaving MAC, so j-1 (mod IN_SIZE) picks x[IN_SIZE-1] in DRAIN.
  assign x_sel     = (j_q == '0) ? JW'(IN_SIZE-1) : j_q - JW'(1);
  assign prod      = $signed(x_q[x_sel]) * $signed(w_data);
  assign acc_sum   = acc_q + {{(ACC_W-16){prod[15]}}, prod};
  assign acc_sum32 = {{(32-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    logit_valid = 1'b0;
    class_valid = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = BIAS;
      end
      BIAS:  state_d = MAC;
      MAC:   if (last_j) state_d = DRAIN;
      DRAIN: state_d = EMIT;
      EMIT: begin
        logit_valid = 1'b1;
        if (logit_ready) state_d = last_n ? DONE : BIAS;
      end
      DONE: begin
        class_valid = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: input latch, neuron/element counters, ROM addresses, accumulator, logit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      n_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      w_addr      <= '0;
      b_addr      <= '0;
      logit_data  <= '0;
      class_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          x_q    <= x_vec;
          n_q    <= '0;
          b_addr <= '0;
        end
        BIAS: begin
          j_q    <= '0;
          w_addr <= W_AW'(int'(n_q) * IN_SIZE);
        end
        MAC: begin
          acc_q <= (j_q == '0) ? {{(ACC_W-8){b_data[7]}}, b_data} : acc_sum;
          j_q   <= last_j ? '0 : j_q + JW'(1);
          if (!last_j) w_addr <= w_addr + W_AW'(1);
        end
        DRAIN: begin
          acc_q      <= acc_sum;
          logit_data <= sat16(acc_sum32);
        end
        EMIT: if (accept && !last_n) begin
          n_q    <= n_q + B_AW'(1);
          b_addr <= n_q + B_AW'(1);
        end
        DONE: class_idx_q <= best_idx;
        default: ;
      endcase
    end
  end

  argmax_tracker #(.IDX_W(B_AW), .VAL_W(16)) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    ((state_q == IDLE) && start),
    .valid    (accept),
    .idx      (n_q),
    .value    ($signed(logit_data)),
    .best_idx (best_idx),
    .best_val (best_val)
  );

  // The winner is already final in DONE, so expose it alongside the class_valid pulse.
  assign class_idx   = (state_q == DONE) ? best_idx : class_idx_q;
  assign logit_idx   = n_q;
  assign unused_best = ^best_val;

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Directed bench for output_layer_sequencer with IN_SIZE=4, OUT_SIZE=3 and 1-cycle ROMs.
module tb_output_layer_sequencer;

  localparam int IN = 4, OUT = 3, ACC = 24, WAW = 4, BAW = 2;
  localparam int NEURON_CYC = IN + 3;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, logit_ready = 1'b1;
  logic [IN*8-1:0] x_vec = '0;
  logic [WAW-1:0]  w_addr;
  logic [BAW-1:0]  b_addr, logit_idx, class_idx;
  logic [7:0]      w_data, b_data;
  logic [15:0]     logit_data;
  logic            logit_valid, busy, class_valid;

  logic [7:0] wrom [0:IN*OUT-1];
  logic [7:0] brom [0:OUT-1];

  int checks = 0, errors = 0;

  typedef struct packed {
    logic [IN-1:0][7:0]     x;
    logic [IN*OUT-1:0][7:0] w;
    logic [OUT-1:0][7:0]    b;
    logic [OUT-1:0][15:0]   lg;
    logic [BAW-1:0]         cls;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    w_data <= wrom[w_addr];
    b_data <= brom[b_addr];
  end

  output_layer_sequencer #(.IN_SIZE(IN), .OUT_SIZE(OUT), .ACC_W(ACC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_vec(x_vec),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .logit_valid(logit_valid), .logit_ready(logit_ready), .logit_idx(logit_idx),
    .logit_data(logit_data), .busy(busy), .class_valid(class_valid), .class_idx(class_idx)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_rom(input int v);
    for (int i = 0; i < IN*OUT; i++) wrom[i] = vecs[v].w[i];
    for (int i = 0; i < OUT; i++)    brom[i] = vecs[v].b[i];
  endtask

  // Runs vector v; optionally stalls neuron stall_n for stall_len cycles and/or
  // injects a second start with a different x_vec while busy.
  task automatic run_case(input int v, input int stall_n, input int stall_len, input bit mid_start);
    int k, got, stalled, exp_cyc;
    bit done, snap;
    logic [15:0] sd; logic [BAW-1:0] si, sba; logic [WAW-1:0] swa;
    load_rom(v);
    exp_cyc = OUT*NEURON_CYC + 1 + stall_len;
    @(negedge clk);
    x_vec = vecs[v].x; start = 1'b1; logit_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0; got = 0; stalled = 0; done = 0; snap = 0;
    sd = '0; si = '0; sba = '0; swa = '0;
    while (!done && k < 200) begin
      @(negedge clk); k++;
      if (mid_start) begin
        start = (k == 5);
        if (k == 5) x_vec = {IN{8'h7f}};
      end
      if (logit_valid && int'(logit_idx) == stall_n && stalled < stall_len) begin
        logit_ready = 1'b0;
        if (!snap) begin
          sd = logit_data; si = logit_idx; swa = w_addr; sba = b_addr; snap = 1;
        end else begin
          chk("stall_data", logit_data, sd);
          chk("stall_idx", logit_idx, si);
          chk("stall_w_addr", w_addr, swa);
          chk("stall_b_addr", b_addr, sba);
        end
        stalled++;
      end else begin
        logit_ready = 1'b1;
        if (logit_valid) begin
          if (got < OUT) begin
            chk("logit_idx", logit_idx, got);
            chk("logit_data", $signed(logit_data), $signed(vecs[v].lg[got]));
          end
          got++;
        end
      end
      if (class_valid) begin
        chk("class_idx", class_idx, vecs[v].cls);
        chk("class_latency", k, exp_cyc);
        chk("busy_in_done", busy, 1);
        chk("logit_count", got, OUT);
        done = 1;
      end
    end
    if (!done) chk("class_valid_timeout", k, exp_cyc);
    @(negedge clk);
    chk("class_valid_pulse", class_valid, 0);
    chk("busy_after_done", busy, 0);
    chk("class_idx_held", class_idx, vecs[v].cls);
  endtask

  initial begin
    // x=[1,2,3,4], rows 1/2/-1, b=[5,0,0] -> 15, 20, -10, class 1
    vecs[0].x = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
    vecs[0].w = {{4{8'hff}}, {4{8'h02}}, {4{8'h01}}};
    vecs[0].b = {8'h00, 8'h00, 8'h05};
    vecs[0].lg = {16'hfff6, 16'd20, 16'd15};
    vecs[0].cls = 2'd0 + 2'd1;
    // saturation both ways: 65663 -> 32767, -65152 -> -32768, row2 zero
    vecs[1].x = {IN{8'h80}};
    vecs[1].w = {{4{8'h00}}, {4{8'h7f}}, {4{8'h80}}};
    vecs[1].b = {8'h00, 8'h80, 8'h7f};
    vecs[1].lg = {16'h0000, 16'h8000, 16'h7fff};
    vecs[1].cls = 2'd0;
    // identical rows -> 7,7,7, tie keeps index 0
    vecs[2].x = {IN{8'h01}};
    vecs[2].w = {(IN*OUT){8'h01}};
    vecs[2].b = {OUT{8'h03}};
    vecs[2].lg = {OUT{16'd7}};
    vecs[2].cls = 2'd0;
    // bias-only logits 0,0,10 -> last neuron wins
    vecs[3].x = {IN{8'h01}};
    vecs[3].w = '0;
    vecs[3].b = {8'd10, 8'd0, 8'd0};
    vecs[3].lg = {16'd10, 16'd0, 16'd0};
    vecs[3].cls = 2'd2;

    load_rom(0);
    #12;
    chk("rst_logit_valid", logit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_logit_data", logit_data, 0);
    chk("rst_w_addr", w_addr, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 4; v++) run_case(v, -1, 0, 1'b0);

    run_case(0, 1, 5, 1'b0);   // backpressure on neuron 1
    run_case(0, -1, 0, 1'b1);  // start while busy is ignored

    // reset during MAC of neuron 1
    load_rom(0);
    @(negedge clk);
    x_vec = vecs[0].x; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_logit_valid", logit_valid, 0);
    chk("midrst_class_valid", class_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_w_addr", w_addr, 0);
    chk("midrst_b_addr", b_addr, 0);
    chk("midrst_logit_idx", logit_idx, 0);
    chk("midrst_logit_data", logit_data, 0);
    chk("midrst_class_idx", class_idx, 0);
    @(negedge clk) rst_n = 1'b1;
    run_case(0, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_layer_sequencer.md
Name: output_layer_sequencer

Overview:
- Time-multiplexed controller for the network's final dense layer (layer 4).
- Latches the layer-4 input vector on `start`, then for each output neuron: reads bias and weights from single-port ROMs, runs a sequential MAC and saturates the result to a 16-bit logit.
- Streams each logit to the downstream softmax/exp-LUT stage over a valid/ready handshake.
- Tracks the running argmax and reports the winning class index when the layer completes.

Parameters:
- IN_SIZE, 64, elements in the input vector (≥2).
- OUT_SIZE, 10, output neurons/classes (≥2).
- ACC_W, 24, accumulator width; must cover IN_SIZE·2^14 + 2^7.
- W_AW, $clog2(IN_SIZE*OUT_SIZE), weight ROM address width.
- B_AW, $clog2(OUT_SIZE), bias ROM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- x_vec  in  IN_SIZE*8  packed signed int8 inputs; element j is x_vec[8j+7:8j]; sampled on the accepted start.
- w_addr  out  W_AW  weight ROM address = n*IN_SIZE + j.
- w_data  in  8  signed weight; valid 1 cycle after w_addr.
- b_addr  out  B_AW  bias ROM address = n.
- b_data  in  8  signed bias; valid 1 cycle after b_addr.
- logit_valid  out  1  logit_data/logit_idx valid.
- logit_ready  in  1  downstream accepts the logit.
- logit_idx  out  B_AW  neuron index of the current logit.
- logit_data  out  16  signed saturated logit.
- busy  out  1  high from the accepted start until DONE, inclusive.
- class_valid  out  1  one-cycle pulse when classification completes.
- class_idx  out  B_AW  argmax index; held until the next accepted start.

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE; all outputs 0; latched inputs, accumulator and argmax registers 0.
- FSM states and transitions:
  - IDLE: on start, latch x_vec, n=0, clear argmax → BIAS.
  - BIAS (1 cycle): drive b_addr=n → MAC, j=0.
  - MAC (IN_SIZE cycles): drive w_addr=n*IN_SIZE+j.
    - First MAC cycle: acc ← sext(b_data).
    - Later cycles: acc += x[j-1]*w_data.
    - j increments each cycle; after j=IN_SIZE-1 → DRAIN.
  - DRAIN (1 cycle): acc += x[IN_SIZE-1]*w_data; register sat16(acc) into logit_data → EMIT.
  - EMIT: logit_valid=1, logit_idx=n.
    - On logit_valid&&logit_ready: update argmax; then n==OUT_SIZE-1 → DONE, else n++ → BIAS.
  - DONE (1 cycle): class_valid=1 → IDLE.
- Arithmetic:
  - Products are signed 8×8 → 16 bits, sign-extended to ACC_W. No intermediate saturation.
  - sat16: acc > 32767 → 32767; acc < −32768 → −32768; else acc[15:0].
- Argmax:
  - Compares saturated logits; updates only on strictly greater.
  - Ties keep the lower index; neuron 0 always initialises.
  - class_idx is written in DONE.
- Latency with logit_ready held high: IN_SIZE+3 cycles per neuron. class_valid asserts OUT_SIZE*(IN_SIZE+3)+1 cycles after the accepted start.
- Backpressure: while in EMIT with ready low, logit_valid/idx/data are held stable and no ROM address changes. The stall may last indefinitely.
- Addresses: w_addr/b_addr hold their last value outside MAC/BIAS. Reads are side-effect-free, so no read enable is needed.
- start while busy: ignored, with no effect on state or latched inputs.
- Reset mid-operation: immediate return to IDLE; logit_valid and class_valid drop asynchronously; no partial class is reported.
- start coinciding with the DONE cycle: ignored, because DONE is not IDLE.

Decomposition:
- nn_parameters package gets: IN_SIZE_4, OUT_SIZE_4, ACC_W_4 constants; `typedef enum logic [2:0] {IDLE,BIAS,MAC,DRAIN,EMIT,DONE} out_seq_state_t`; a sat16 function.
- Sub-module `argmax_tracker`: clear, valid, idx, signed value in; best_idx, best_val out; strict-greater update.
- The ROMs stay outside the block and are loaded by $readmemh from WEIGHTS_FILE_4 and BIAS_FILE_4.

Test Plan (IN_SIZE=4, OUT_SIZE=3, 1-cycle ROM model):
1. x=[1,2,3,4]; W rows [1,1,1,1]/[2,2,2,2]/[−1,−1,−1,−1]; b=[5,0,0]; ready=1 → logits 15, 20, −10 in order with idx 0,1,2; class_idx=1; class_valid exactly 22 cycles after start.
2. x all −128, W row0 all −128, b0=127 → acc=65663 → logit0=32767. Row1 all 127 with x=−128, b1=−128 → −65152 → −32768.
3. All rows and biases identical (logits 7,7,7) → class_idx=0.
4. logit_ready low for 5 cycles on neuron 1 → logit_valid/idx/data stable; w_addr/b_addr frozen; completion delayed by exactly 5 cycles; results unchanged.
5. Assert rst_n=0 during MAC of neuron 1 → all outputs 0 immediately. A new start after release gives the scenario-1 results.
6. Second start pulse mid-run with different x_vec → ignored; results match the first x_vec.
